// File: rtl/logic_gate_pipe.sv
// Registered bitwise gate unit with a main + skid output buffer on a valid/ready stream.
// Optional feature: define LOGIC_PARITY_EN to add the out_parity port and per-entry parity storage.
module logic_gate_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef LOGIC_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  typedef enum logic [2:0] {
    OP_NOT  = 3'd0,
    OP_AND  = 3'd1,
    OP_OR   = 3'd2,
    OP_XOR  = 3'd3,
    OP_NAND = 3'd4,
    OP_NOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_PASS = 3'd7
  } op_t;

  logic [WIDTH-1:0] result;
  logic             main_valid;
  logic [WIDTH-1:0] main_data;
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             accept;
  logic             transfer;

  always_comb begin
    result = '0;
    unique case (op_t'(in_op))
      OP_NOT:  result = ~in_a;
      OP_AND:  result = in_a & in_b;
      OP_OR:   result = in_a | in_b;
      OP_XOR:  result = in_a ^ in_b;
      OP_NAND: result = ~(in_a & in_b);
      OP_NOR:  result = ~(in_a | in_b);
      OP_XNOR: result = ~(in_a ^ in_b);
      OP_PASS: result = in_a;
      default: result = '0;
    endcase
  end

  // in_ready comes straight off the skid flag, so out_ready never reaches it combinationally.
  assign in_ready  = ~skid_valid;
  assign accept    = in_valid & ~skid_valid;
  assign transfer  = main_valid & out_ready;
  assign out_valid = main_valid;
  assign out_data  = main_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (!main_valid) begin
      if (accept) begin
        main_valid <= 1'b1;
        main_data  <= result;
      end
    end else if (transfer) begin
      if (skid_valid) begin
        main_data  <= skid_data;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_data  <= result;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= result;
    end
  end

`ifdef LOGIC_PARITY_EN
  logic main_par;
  logic skid_par;
  logic result_par;

  assign result_par = ^result;
  assign out_parity = main_par;

  // Parity follows exactly the same moves as the data entries it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_par <= 1'b0;
      skid_par <= 1'b0;
    end else if (!main_valid) begin
      if (accept) main_par <= result_par;
    end else if (transfer) begin
      if (skid_valid)  main_par <= skid_par;
      else if (accept) main_par <= result_par;
    end else if (accept) begin
      skid_par <= result_par;
    end
  end
`endif

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Directed self-checking bench for logic_gate_pipe at widths 8, 1, 32 and 64.
// Parity checks are compiled in when LOGIC_PARITY_EN is defined.
module tb_logic_gate_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   assertCount = 0;
  int   failCount = 0;

  always #5 clk = ~clk;

  logic       inValid, inReady, outValid, outReady;
  logic [7:0] inA, inB, outData;
  logic [2:0] inOp;
`ifdef LOGIC_PARITY_EN
  logic       outParity;
`endif

  logic        v1, r1, ov1;
  logic [0:0]  a1, b1, d1;
  logic [2:0]  op1;
  logic        v32, r32, ov32;
  logic [31:0] a32, b32, d32;
  logic [2:0]  op32;
  logic        v64, r64, ov64;
  logic [63:0] a64, b64, d64;
  logic [2:0]  op64;
`ifdef LOGIC_PARITY_EN
  logic        p1, p32, p64;
`endif

  logic_gate_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady),
    .in_a(inA), .in_b(inB), .in_op(inOp), .out_valid(outValid),
    .out_ready(outReady), .out_data(outData)
`ifdef LOGIC_PARITY_EN
    , .out_parity(outParity)
`endif
  );

  logic_gate_pipe #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1),
    .in_a(a1), .in_b(b1), .in_op(op1), .out_valid(ov1),
    .out_ready(1'b1), .out_data(d1)
`ifdef LOGIC_PARITY_EN
    , .out_parity(p1)
`endif
  );

  logic_gate_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(r32),
    .in_a(a32), .in_b(b32), .in_op(op32), .out_valid(ov32),
    .out_ready(1'b1), .out_data(d32)
`ifdef LOGIC_PARITY_EN
    , .out_parity(p32)
`endif
  );

  logic_gate_pipe #(.WIDTH(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(v64), .in_ready(r64),
    .in_a(a64), .in_b(b64), .in_op(op64), .out_valid(ov64),
    .out_ready(1'b1), .out_data(d64)
`ifdef LOGIC_PARITY_EN
    , .out_parity(p64)
`endif
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] a, input logic [7:0] b,
                               input logic [2:0] op);
    inValid = v;
    inA = a;
    inB = b;
    inOp = op;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] sweepExp [8] = '{8'h0F, 8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'hF0};

  initial begin
    applyStimulus(1'b0, 8'h00, 8'h00, 3'd0);
    outReady = 1'b1;
    v1 = 1'b0; a1 = '0; b1 = '0; op1 = '0;
    v32 = 1'b0; a32 = '0; b32 = '0; op32 = '0;
    v64 = 1'b0; a64 = '0; b64 = '0; op64 = '0;

    #12;
    checkOutput("reset_out_valid", 64'(outValid), 64'd0);
    checkOutput("reset_out_data", 64'(outData), 64'd0);
    checkOutput("reset_in_ready", 64'(inReady), 64'd1);
    rst_n = 1'b1;

    // single NOT
    @(negedge clk);
    applyStimulus(1'b1, 8'hA5, 8'h00, 3'd0);
    tick();
    checkOutput("single_valid", 64'(outValid), 64'd1);
    checkOutput("single_data", 64'(outData), 64'h5A);
    applyStimulus(1'b0, 8'h00, 8'h00, 3'd0);
    tick();
    checkOutput("single_valid_drop", 64'(outValid), 64'd0);

    // back-to-back op sweep
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 8'hF0, 8'hCC, 3'(i));
      tick();
      checkOutput($sformatf("sweep_valid_op%0d", i), 64'(outValid), 64'd1);
      checkOutput($sformatf("sweep_data_op%0d", i), 64'(outData), 64'(sweepExp[i]));
    end
    applyStimulus(1'b0, 8'h00, 8'h00, 3'd0);
    tick();
    checkOutput("sweep_idle", 64'(outValid), 64'd0);

    // back-pressure with skid fill and drain
    outReady = 1'b0;
    applyStimulus(1'b1, 8'h11, 8'h00, 3'd7);
    tick();
    checkOutput("bp_r1_main", 64'(outData), 64'h11);
    checkOutput("bp_r1_ready", 64'(inReady), 64'd1);
    applyStimulus(1'b1, 8'h22, 8'h00, 3'd7);
    tick();
    checkOutput("bp_r2_ready_low", 64'(inReady), 64'd0);
    checkOutput("bp_r2_hold", 64'(outData), 64'h11);
    applyStimulus(1'b1, 8'h33, 8'h00, 3'd7);
    tick();
    checkOutput("bp_r3_held_data", 64'(outData), 64'h11);
    checkOutput("bp_r3_held_ready", 64'(inReady), 64'd0);
    tick();
    checkOutput("bp_stable_data", 64'(outData), 64'h11);
    checkOutput("bp_stable_valid", 64'(outValid), 64'd1);
    outReady = 1'b1;
    tick();
    checkOutput("bp_drain_r2", 64'(outData), 64'h22);
    checkOutput("bp_drain_ready", 64'(inReady), 64'd1);
    tick();
    checkOutput("bp_drain_r3", 64'(outData), 64'h33);
    checkOutput("bp_drain_r3_valid", 64'(outValid), 64'd1);
    applyStimulus(1'b0, 8'h00, 8'h00, 3'd0);
    tick();
    checkOutput("bp_empty", 64'(outValid), 64'd0);

    // asynchronous reset with both entries full
    outReady = 1'b0;
    applyStimulus(1'b1, 8'h44, 8'h00, 3'd7);
    tick();
    applyStimulus(1'b1, 8'h55, 8'h00, 3'd7);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 3'd0);
    checkOutput("ar_full_pre", 64'(inReady), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("ar_out_valid", 64'(outValid), 64'd0);
    checkOutput("ar_out_data", 64'(outData), 64'd0);
    checkOutput("ar_in_ready", 64'(inReady), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    outReady = 1'b1;
    applyStimulus(1'b1, 8'hF0, 8'hCC, 3'd1);
    tick();
    checkOutput("ar_after_valid", 64'(outValid), 64'd1);
    checkOutput("ar_after_data", 64'(outData), 64'hC0);
    applyStimulus(1'b0, 8'h00, 8'h00, 3'd0);

    // width extremes
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; op1 = 3'd4;
    v32 = 1'b1; a32 = 32'h0000FFFF; b32 = 32'h12345678; op32 = 3'd0;
    v64 = 1'b1; a64 = 64'h0123456789ABCDEF; b64 = 64'h0123456789ABCDEF; op64 = 3'd3;
    tick();
    checkOutput("w1_valid", 64'(ov1), 64'd1);
    checkOutput("w1_nand", 64'(d1), 64'd0);
    checkOutput("w32_not", 64'(d32), 64'hFFFF0000);
    checkOutput("w64_xor_valid", 64'(ov64), 64'd1);
    checkOutput("w64_xor", d64, 64'd0);
    op1 = 3'd5; a1 = 1'b0; b1 = 1'b0;
    op32 = 3'd6; a32 = 32'hF0F0F0F0; b32 = 32'h0FF00FF0;
    op64 = 3'd2; a64 = 64'hF000000000000000; b64 = 64'h000000000000000F;
    tick();
    checkOutput("w1_nor", 64'(d1), 64'd1);
    checkOutput("w32_xnor", 64'(d32), 64'h00FF00FF);
    checkOutput("w64_or", d64, 64'hF00000000000000F);
    v1 = 1'b0; v32 = 1'b0; v64 = 1'b0;
    tick();

`ifdef LOGIC_PARITY_EN
    outReady = 1'b0;
    applyStimulus(1'b1, 8'h0F, 8'h01, 3'd3);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 3'd0);
    checkOutput("par_data", 64'(outData), 64'h0E);
    checkOutput("par_bit", 64'(outParity), 64'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput($sformatf("par_hold%0d", k), 64'(outParity), 64'd1);
      checkOutput($sformatf("par_data_hold%0d", k), 64'(outData), 64'h0E);
    end
    outReady = 1'b1;
    applyStimulus(1'b1, 8'h0F, 8'h03, 3'd3);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 3'd0);
    checkOutput("par_even", 64'(outParity), 64'd0);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
